// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter with burst-limited round robin and registered read return.
// Optional address checking is enabled by defining DMEM_ARB_CHECK_EN.
module dmem_arbiter #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        err0,
  output logic        err1,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAXC = CW'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          g0, g1;

  logic          rvalid0_q, rvalid1_q;
  logic [31:0]   rdata0_q, rdata1_q;

  logic          sel_we;
  logic [31:0]   sel_addr, sel_wdata;
  logic          bad;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    g0      = 1'b0;
    g1      = 1'b0;
    case (state_q)
      OWN0: begin
        if (req0 && (!req1 || cnt_q < MAXC)) g0 = 1'b1;
        else if (req1)                        g1 = 1'b1;
      end
      OWN1: begin
        if (req1 && (!req0 || cnt_q < MAXC)) g1 = 1'b1;
        else if (req0)                        g0 = 1'b1;
      end
      default: begin
        // On contention the requester that did not own the bus last wins.
        if (req0 && req1) begin
          if (last_q) g0 = 1'b1;
          else        g1 = 1'b1;
        end else if (req0) begin
          g0 = 1'b1;
        end else if (req1) begin
          g1 = 1'b1;
        end
      end
    endcase

    if (g0) begin
      state_d = OWN0;
      last_d  = 1'b0;
      if (state_q == OWN0) cnt_d = (cnt_q == MAXC) ? cnt_q : cnt_q + CW'(1);
      else                 cnt_d = CW'(1);
    end else if (g1) begin
      state_d = OWN1;
      last_d  = 1'b1;
      if (state_q == OWN1) cnt_d = (cnt_q == MAXC) ? cnt_q : cnt_q + CW'(1);
      else                 cnt_d = CW'(1);
    end else begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  assign gnt0 = g0 & ~reset;
  assign gnt1 = g1 & ~reset;

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (gnt0) begin
      sel_we    = we0;
      sel_addr  = addr0;
      sel_wdata = wdata0;
    end else if (gnt1) begin
      sel_we    = we1;
      sel_addr  = addr1;
      sel_wdata = wdata1;
    end
  end

`ifdef DMEM_ARB_CHECK_EN
  // Legal window is word-aligned addresses 0x00..0x7C.
  assign bad = (gnt0 | gnt1) & ((sel_addr[1:0] != 2'b00) | (sel_addr[31:7] != '0));
`else
  assign bad = 1'b0;
`endif

  assign mem_we    = sel_we & ~bad;
  assign mem_addr  = sel_addr;
  assign mem_wdata = sel_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rvalid0_q <= gnt0 & ~we0;
      rvalid1_q <= gnt1 & ~we1;
      if (gnt0 && !we0) rdata0_q <= bad ? 32'h0 : mem_rdata;
      if (gnt1 && !we1) rdata1_q <= bad ? 32'h0 : mem_rdata;
    end
  end

  // Masking with reset keeps a read that was in flight from surfacing during reset.
  assign rvalid0 = rvalid0_q & ~reset;
  assign rvalid1 = rvalid1_q & ~reset;
  assign rdata0  = reset ? 32'h0 : rdata0_q;
  assign rdata1  = reset ? 32'h0 : rdata1_q;

`ifdef DMEM_ARB_CHECK_EN
  logic err0_q, err1_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      err0_q <= 1'b0;
      err1_q <= 1'b0;
    end else begin
      err0_q <= gnt0 & bad;
      err1_q <= gnt1 & bad;
    end
  end

  assign err0 = err0_q & ~reset;
  assign err1 = err1_q & ~reset;
`else
  assign err0 = 1'b0;
  assign err1 = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: grant-sequence table, scoreboard for read returns,
// and hand sequences for reset cancellation and address checking.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_we;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

  dmem_arbiter #(.MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [256];
  always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
  assign mem_rdata = mem[mem_addr[9:2]];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct { bit port; logic [31:0] data; } sb_t;
  sb_t sbq[$];
  sb_t sb_e;

  always @(negedge clk) begin
    if (rvalid0 || rvalid1) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rvalid_unexpected: got rvalid0=%b rvalid1=%b expected none", rvalid0, rvalid1);
      end else begin
        sb_e = sbq.pop_front();
        chk("rvalid_port", {31'b0, rvalid1}, {31'b0, sb_e.port});
        chk("rdata", sb_e.port ? rdata1 : rdata0, sb_e.data);
      end
    end
  end

  task automatic drive(input bit r0, input bit w0, input logic [31:0] a0, input logic [31:0] d0,
                       input bit r1, input bit w1, input logic [31:0] a1, input logic [31:0] d1);
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    next();
    reset = 1'b0;
  endtask

  typedef struct { bit r0; bit r1; bit g0; bit g1; } vec_t;
  vec_t tbl[26];

  logic [31:0] m20, m24, exp_addr;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    reset = 1'b1;
    drive(1, 1, 32'h4, 32'h55, 1, 1, 32'h8, 32'h66);

    // reset holds off grants even with requests pending
    @(negedge clk);
    chk("rst_gnt0", {31'b0, gnt0}, 0);
    chk("rst_gnt1", {31'b0, gnt1}, 0);
    chk("rst_mem_we", {31'b0, mem_we}, 0);
    next();
    reset = 1'b0;
    idle();
    @(negedge clk);
    chk("post_rst_rvalid", {30'b0, rvalid1, rvalid0}, 0);
    chk("post_rst_rdata0", rdata0, 0);
    chk("post_rst_rdata1", rdata1, 0);
    chk("post_rst_err", {30'b0, err1, err0}, 0);
    chk("rst_no_write", mem[1], 0);
    next();

    // write then read back on port 0
    drive(1, 1, 32'h8, 32'hDEADBEEF, 0, 0, 0, 0);
    @(negedge clk);
    chk("wr_gnt0", {31'b0, gnt0}, 1);
    chk("wr_gnt1", {31'b0, gnt1}, 0);
    chk("wr_mem_we", {31'b0, mem_we}, 1);
    chk("wr_mem_addr", mem_addr, 32'h8);
    chk("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
    next();
    drive(1, 0, 32'h8, 0, 0, 0, 0, 0);
    sbq.push_back('{1'b0, 32'hDEADBEEF});
    @(negedge clk);
    chk("rd_gnt0", {31'b0, gnt0}, 1);
    chk("rd_mem_we", {31'b0, mem_we}, 0);
    next();
    idle();
    @(negedge clk);
    chk("rd_rvalid0", {31'b0, rvalid0}, 1);
    next();
    @(negedge clk);
    chk("rd_pulse_end", {31'b0, rvalid0}, 0);
    chk("rd_hold", rdata0, 32'hDEADBEEF);
    chk("idle_mem_addr", mem_addr, 0);
    next();

    // grant-sequence table, starting from a fresh reset
    for (int i = 0; i < 12; i++) tbl[i] = '{1'b1, 1'b1, (i < 4 || i >= 8), (i >= 4 && i < 8)};
    tbl[12] = '{0, 0, 0, 0};
    tbl[13] = '{1, 0, 1, 0};
    tbl[14] = '{1, 1, 1, 0};
    tbl[15] = '{0, 1, 0, 1};
    tbl[16] = '{1, 1, 0, 1};
    tbl[17] = '{1, 0, 1, 0};
    tbl[18] = '{1, 1, 1, 0};
    tbl[19] = '{1, 1, 1, 0};
    tbl[20] = '{1, 1, 1, 0};
    tbl[21] = '{1, 1, 0, 1};
    tbl[22] = '{0, 0, 0, 0};
    tbl[23] = '{1, 1, 1, 0};
    tbl[24] = '{0, 1, 0, 1};
    tbl[25] = '{0, 0, 0, 0};

    do_reset();
    m20 = 32'h0;
    m24 = 32'h0;
    for (int i = 0; i < 26; i++) begin
      drive(tbl[i].r0, 1, 32'h20, 32'hA000_0000 | i, tbl[i].r1, 1, 32'h24, 32'hB000_0000 | i);
      exp_addr = tbl[i].g0 ? 32'h20 : (tbl[i].g1 ? 32'h24 : 32'h0);
      if (tbl[i].g0) m20 = 32'hA000_0000 | i;
      if (tbl[i].g1) m24 = 32'hB000_0000 | i;
      @(negedge clk);
      chk($sformatf("tbl%0d_gnt0", i), {31'b0, gnt0}, {31'b0, tbl[i].g0});
      chk($sformatf("tbl%0d_gnt1", i), {31'b0, gnt1}, {31'b0, tbl[i].g1});
      chk($sformatf("tbl%0d_mem_addr", i), mem_addr, exp_addr);
      chk($sformatf("tbl%0d_onehot", i), {31'b0, gnt0 & gnt1}, 0);
      next();
    end

    // read back the last writes from each port through the other port
    drive(1, 0, 32'h24, 0, 0, 0, 0, 0);
    sbq.push_back('{1'b0, m24});
    next();
    drive(0, 0, 0, 0, 1, 0, 32'h20, 0);
    sbq.push_back('{1'b1, m20});
    @(negedge clk);
    chk("rb_gnt1", {31'b0, gnt1}, 1);
    next();
    idle();
    next();

    // reset right after a read grant cancels the return
    do_reset();
    drive(0, 0, 0, 0, 1, 0, 32'h8, 0);
    @(negedge clk);
    chk("cancel_gnt1", {31'b0, gnt1}, 1);
    next();
    reset = 1'b1;
    idle();
    @(negedge clk);
    chk("cancel_rvalid1_rst", {31'b0, rvalid1}, 0);
    chk("cancel_rdata1_rst", rdata1, 0);
    next();
    reset = 1'b0;
    @(negedge clk);
    chk("cancel_rvalid1_after", {31'b0, rvalid1}, 0);
    chk("cancel_rdata1_after", rdata1, 0);
    next();
    @(negedge clk);
    chk("cancel_rdata1_later", rdata1, 0);
    next();

    // out-of-range and misaligned accesses
    drive(1, 1, 32'h82, 32'h1234_5678, 0, 0, 0, 0);
    @(negedge clk);
    chk("bad_wr_gnt0", {31'b0, gnt0}, 1);
`ifdef DMEM_ARB_CHECK_EN
    chk("bad_wr_mem_we", {31'b0, mem_we}, 0);
`else
    chk("bad_wr_mem_we", {31'b0, mem_we}, 1);
`endif
    next();
    drive(1, 1, 32'h42, 32'hCAFE_0042, 0, 0, 0, 0);
    @(negedge clk);
`ifdef DMEM_ARB_CHECK_EN
    chk("bad_wr_err0", {31'b0, err0}, 1);
`else
    chk("bad_wr_err0", {31'b0, err0}, 0);
`endif
    next();
    drive(1, 0, 32'h40, 0, 0, 0, 0, 0);
`ifdef DMEM_ARB_CHECK_EN
    sbq.push_back('{1'b0, 32'h0});
`else
    sbq.push_back('{1'b0, 32'hCAFE_0042});
`endif
    next();
    drive(1, 0, 32'h82, 0, 0, 0, 0, 0);
`ifdef DMEM_ARB_CHECK_EN
    sbq.push_back('{1'b0, 32'h0});
`else
    sbq.push_back('{1'b0, 32'h1234_5678});
`endif
    @(negedge clk);
    chk("good_rd_err0", {31'b0, err0}, 0);
    next();
    idle();
    @(negedge clk);
`ifdef DMEM_ARB_CHECK_EN
    chk("bad_rd_err0", {31'b0, err0}, 1);
`else
    chk("bad_rd_err0", {31'b0, err0}, 0);
`endif
    next();
    @(negedge clk);
    chk("err_pulse_end", {30'b0, err1, err0}, 0);
    next();
    next();

    chk("sb_drain", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: MAX_BURST, default 4, max consecutive grants to one requester while the other waits; legal range 1..255.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0/req1  input  1  access request, requester 0/1.
REQ-005 we0/we1  input  1  1=write, 0=read.
REQ-006 addr0/addr1  input  32  byte address, word-aligned.
REQ-007 wdata0/wdata1  input  32  write data.
REQ-008 gnt0/gnt1  output  1  combinational grant; access performed this cycle.
REQ-009 rvalid0/rvalid1  output  1  read data valid, one-cycle pulse.
REQ-010 rdata0/rdata1  output  32  registered read data.
REQ-011 err0/err1  output  1  access-error pulse (see Configuration).
REQ-012 mem_we  output  1  memory write enable.
REQ-013 mem_addr  output  32  memory address.
REQ-014 mem_wdata  output  32  memory write data.
REQ-015 mem_rdata  input  32  combinational memory read data.

Function
REQ-016 At most one of gnt0/gnt1 SHALL be high in any cycle; a grant requires the matching req high.
REQ-017 mem_addr/mem_wdata SHALL mux from the granted requester; mem_we = granted we; with no grant, mem_we=0 and mem_addr/mem_wdata=0.
REQ-018 Writes SHALL take effect at the rising edge ending the grant cycle; a write grant produces no rvalid.
REQ-019 Granted read: rdataN SHALL capture mem_rdata at the edge ending the grant cycle; rvalidN high the following cycle only; rdataN holds until the next read to N completes.
REQ-020 States: IDLE (no grant last cycle), OWN0, OWN1 (owner granted last cycle); burst counter cnt, width ceil(log2(MAX_BURST+1)).
REQ-021 IDLE: one request -> grant it, enter its OWN state, cnt=1; both -> grant requester != last_owner; none -> stay IDLE, cnt=0.
REQ-022 OWNn: reqn high and (other idle or cnt<MAX_BURST) -> grant n, cnt=cnt+1 saturating at MAX_BURST.
REQ-023 OWNn: otherwise, other requesting -> grant other, enter its OWN state, cnt=1.
REQ-024 OWNn: no requests -> IDLE, cnt=0.
REQ-025 last_owner SHALL update to the granted index on every grant.
REQ-026 Both requesting continuously with MAX_BURST=M: grants alternate in runs of exactly M; MAX_BURST=1 gives strict alternation.
REQ-027 Requester dropping req mid-burst: no grant that cycle; arbitration per REQ-022..024 with no waiting penalty.

Reset
REQ-028 While reset high: gnt0=gnt1=0, mem_we=0, no memory write.
REQ-029 After reset: state=IDLE, cnt=0, last_owner=1 (requester 0 wins first contention), rvalid0/1=0, rdata0/1=0, err0/1=0.
REQ-030 Reset asserted mid-burst or with a read in flight SHALL cancel it: no rvalid/err pulse follows reset.

Configuration
REQ-031 Macro DMEM_ARB_CHECK_EN defined: a granted access with addr[1:0]!=0 or addr[31:7]!=0 is an error: grant still issued, mem_we forced 0, errN pulses the next cycle; an erroneous read additionally pulses rvalidN with rdataN=0.
REQ-032 DMEM_ARB_CHECK_EN undefined: err0/err1 tied 0; all accesses pass unchecked.

Verification
REQ-033 Reset, then req0 write addr=0x8 wdata=0xDEADBEEF -> gnt0=1, mem_we=1 same cycle; next cycle req0 read 0x8 -> rvalid0 following cycle, rdata0=0xDEADBEEF.
REQ-034 MAX_BURST=4, req0/req1 both held high 12 cycles from reset -> grant sequence 0000 1111 0000, never both high.
REQ-035 OWN0 with cnt=2, req0 drops, req1 high -> gnt1 same cycle, state OWN1, cnt=1.
REQ-036 Read granted to requester 1, reset asserted next cycle -> rvalid1=0, rdata1=0 during and after reset.
REQ-037 DMEM_ARB_CHECK_EN: req0 write addr=0x82 -> gnt0=1, mem_we=0, err0 pulse next cycle; memory word unchanged on readback. Without macro: err0 stays 0.
